// File: rtl/chat_sweep_ctrl.sv
// rtl/chat_sweep_ctrl.sv - 32-vector truth-table sweep controller with mismatch counting.
module chat_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [4:0] stim,
  input  logic       resp_out1,
  input  logic       resp_out2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] vec_idx,
  output logic [5:0] mismatch_cnt,
  output logic [4:0] first_fail_idx,
  output logic       first_fail_valid
);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [7:0] settle_cnt;
  logic       exp1;
  logic       exp2;
  logic       mis;

  // Reference model evaluated on the vector index, not on the stim register.
  assign exp1 = ~((~vec_idx[4] & vec_idx[3]) | (vec_idx[2] & ~vec_idx[3]));
  assign exp2 = (vec_idx[1] & ~vec_idx[0]) | exp1;
  assign mis  = (resp_out1 != exp1) || (resp_out2 != exp2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      stim             <= '0;
      vec_idx          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      mismatch_cnt     <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
      settle_cnt       <= '0;
    end else if (abort && busy) begin
      // Results so far stay visible for diagnosis.
      state <= IDLE;
      stim  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start && !abort) begin
            mismatch_cnt     <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            vec_idx          <= '0;
            busy             <= 1'b1;
            state            <= APPLY;
          end
        end
        APPLY: begin
          stim       <= vec_idx;
          settle_cnt <= SETTLE_LOAD;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == 8'd0) state <= SAMPLE;
          else settle_cnt <= settle_cnt - 8'd1;
        end
        SAMPLE: begin
          if (mis) begin
            if (mismatch_cnt < 6'd32) mismatch_cnt <= mismatch_cnt + 6'd1;
            if (!first_fail_valid) begin
              first_fail_idx   <= vec_idx;
              first_fail_valid <= 1'b1;
            end
          end
          if (vec_idx == 5'd31) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            stim  <= '0;
            pass  <= (mismatch_cnt == 6'd0) && !mis;
          end else begin
            vec_idx <= vec_idx + 5'd1;
            state   <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chat_sweep_ctrl.sv
// tb/tb_chat_sweep_ctrl.sv - table-driven self-checking bench for chat_sweep_ctrl.
module tb_chat_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
  logic [2:0] mode0 = 3'd0, mode1 = 3'd0;

  logic [4:0] stim0, vec_idx0, ffi0, stim1, vec_idx1, ffi1;
  logic [5:0] cnt0, cnt1;
  logic       busy0, done0, pass0, ffv0, r1_0, r2_0;
  logic       busy1, done1, pass1, ffv1, r1_1, r2_1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Circuit-under-test model with selectable faults.
  function automatic logic [1:0] cut(input logic [4:0] s, input logic [2:0] mode);
    logic e1, e2;
    e1 = ~((~s[4] & s[3]) | (s[2] & ~s[3]));
    e2 = (s[1] & ~s[0]) | e1;
    case (mode)
      3'd1:    return {e1, 1'b0};
      3'd2:    return {1'b1, e2};
      3'd3:    return {1'b0, e2};
      3'd4:    return {~e1, ~e2};
      default: return {e1, e2};
    endcase
  endfunction

  assign {r1_0, r2_0} = cut(stim0, mode0);
  assign {r1_1, r2_1} = cut(stim1, mode1);

  chat_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .stim(stim0),
    .resp_out1(r1_0), .resp_out2(r2_0), .busy(busy0), .done(done0), .pass(pass0),
    .vec_idx(vec_idx0), .mismatch_cnt(cnt0), .first_fail_idx(ffi0), .first_fail_valid(ffv0)
  );

  chat_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .stim(stim1),
    .resp_out1(r1_1), .resp_out2(r2_1), .busy(busy1), .done(done1), .pass(pass1),
    .vec_idx(vec_idx1), .mismatch_cnt(cnt1), .first_fail_idx(ffi1), .first_fail_valid(ffv1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse start on dut, return edges from start edge until done; optional stray start at inj_cyc.
  task automatic run_sweep(input int inj_cyc, output int cyc);
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    cyc = 0;
    while (!done0 && cyc < 1000) begin
      if (cyc == inj_cyc) start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      cyc++;
    end
  endtask

  typedef struct {
    logic [2:0] mode;
    int         cnt;
    int         ffi;
    int         ffv;
    int         pass;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int cyc, bad;
    tbl[0] = '{3'd0,  0, 0, 0, 1};
    tbl[1] = '{3'd1, 20, 0, 1, 0};
    tbl[2] = '{3'd2, 16, 4, 1, 0};
    tbl[3] = '{3'd3, 16, 0, 1, 0};
    tbl[4] = '{3'd4, 32, 0, 1, 0};

    #1;
    chk("reset_stim", stim0, 0);
    chk("reset_busy", busy0, 0);
    chk("reset_done", done0, 0);
    chk("reset_cnt", cnt0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      mode0 = tbl[i].mode;
      run_sweep(-1, cyc);
      chk($sformatf("sweep%0d_cycles", i), cyc, 192);
      chk($sformatf("sweep%0d_cnt", i), cnt0, tbl[i].cnt);
      chk($sformatf("sweep%0d_ffi", i), ffi0, tbl[i].ffi);
      chk($sformatf("sweep%0d_ffv", i), ffv0, tbl[i].ffv);
      chk($sformatf("sweep%0d_pass", i), pass0, tbl[i].pass);
      chk($sformatf("sweep%0d_stim_done", i), stim0, 0);
      chk($sformatf("sweep%0d_busy_done", i), busy0, 0);
    end

    // Abort during vector 10 settle, with out2 stuck low.
    mode0 = 3'd1;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    chk("start_clears_done", done0, 0);
    cyc = 0;
    while (!(vec_idx0 == 5'd10 && stim0 == 5'd10) && cyc < 1000) begin
      @(posedge clk); #1; cyc++;
    end
    chk("reach_vec10", vec_idx0, 10);
    @(negedge clk); abort0 = 1'b1;
    @(posedge clk); #1; abort0 = 1'b0;
    chk("abort_busy", busy0, 0);
    chk("abort_stim", stim0, 0);
    chk("abort_done", done0, 0);
    chk("abort_cnt_kept", cnt0, 5);
    chk("abort_ffv_kept", ffv0, 1);
    // Simultaneous abort and start in idle: start must lose.
    @(negedge clk); abort0 = 1'b1; start0 = 1'b1;
    @(posedge clk); #1; abort0 = 1'b0; start0 = 1'b0;
    chk("abort_prio_busy", busy0, 0);
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    chk("restart_vec", vec_idx0, 0);
    chk("restart_cnt", cnt0, 0);
    chk("restart_ffv", ffv0, 0);
    chk("restart_busy", busy0, 1);
    cyc = 0;
    while (!done0 && cyc < 1000) begin @(posedge clk); #1; cyc++; end
    chk("restart_cycles", cyc, 192);

    // Stray start at vector 5 is ignored.
    mode0 = 3'd0;
    run_sweep(33, cyc);
    chk("stray_start_cycles", cyc, 192);
    chk("stray_start_pass", pass0, 1);

    // Reset during vector 20.
    mode0 = 3'd1;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    repeat (123) @(posedge clk);
    #2;
    chk("pre_reset_vec", vec_idx0, 20);
    rst_n = 1'b0;
    #1;
    chk("async_rst_stim", stim0, 0);
    chk("async_rst_vec", vec_idx0, 0);
    chk("async_rst_busy", busy0, 0);
    chk("async_rst_cnt", cnt0, 0);
    chk("async_rst_ffv", ffv0, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_idle_busy", busy0, 0);
    chk("post_rst_idle_done", done0, 0);

    // SETTLE_CYCLES=1: 96 cycles, stim stable per vector window.
    mode1 = 3'd0;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    cyc = 0;
    bad = 0;
    while (!done1 && cyc < 1000) begin
      @(posedge clk); #1; cyc++;
      if (cyc < 96 && stim1 != 5'((cyc - 1) / 3)) bad++;
    end
    chk("s1_cycles", cyc, 96);
    chk("s1_stim_unstable", bad, 0);
    chk("s1_pass", pass1, 1);
    chk("s1_cnt", cnt1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chat_sweep_ctrl.md
CHAT_SWEEP_CTRL -- requirements
Module: chat_sweep_ctrl

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset; no other clocks or resets.
REQ-002 Parameter SETTLE_CYCLES, default 4, SHALL set the wait in cycles between applying a vector and sampling the response (legal range 1..255).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle pulse that starts a full 32-vector truth-table sweep.
REQ-006 abort  input  1  terminates a sweep in progress.
REQ-007 stim  output  5  drive to circuit under test: stim[4]=a, stim[3]=b, stim[2]=c, stim[1]=d, stim[0]=e.
REQ-008 resp_out1, resp_out2  input  1 each  circuit outputs out1 and out2, synchronous to clk.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  high when a sweep has completed; held until the next accepted start or reset.
REQ-011 pass  output  1  valid with done; 1 iff mismatch_cnt==0.
REQ-012 vec_idx  output  5  index of the vector currently applied.
REQ-013 mismatch_cnt  output  6  number of vectors with any output mismatch, range 0..32.
REQ-014 first_fail_idx  output  5  lowest failing vector index; first_fail_valid  output  1  marks it valid.

Function
REQ-015 Expected model: exp1 = NOR((~a & b), (c & ~b)); exp2 = (d & ~e) | exp1.
REQ-016 FSM states SHALL be IDLE, APPLY, SETTLE, SAMPLE and DONE.
REQ-017 IDLE/DONE + start: clear mismatch_cnt, first_fail_idx, first_fail_valid and done; set vec_idx=0; go to APPLY.
REQ-018 APPLY (1 cycle): stim <= vec_idx; load settle counter; go to SETTLE.
REQ-019 SETTLE: hold stim; stay SETTLE_CYCLES cycles; then go to SAMPLE.
REQ-020 SAMPLE (1 cycle): compare resp_out1/resp_out2 with exp1/exp2 for vec_idx; on any mismatch increment mismatch_cnt by exactly 1; if first_fail_valid==0, capture first_fail_idx=vec_idx and set first_fail_valid.
REQ-021 After SAMPLE: if vec_idx==31 go to DONE; else vec_idx+1 and go to APPLY. vec_idx SHALL NOT wrap.
REQ-022 Per-vector time SHALL be SETTLE_CYCLES+2 cycles; a full sweep SHALL take 32*(SETTLE_CYCLES+2) cycles from the start edge to done=1 (192 at default).
REQ-023 DONE: busy=0, done=1, pass=(mismatch_cnt==0); stim SHALL return to 5'b00000.
REQ-024 busy SHALL be 1 in APPLY, SETTLE and SAMPLE only.
REQ-025 start while busy SHALL be ignored.
REQ-026 abort while busy SHALL go to IDLE next cycle: stim=0, busy=0, done=0; mismatch_cnt and first_fail_* retain their values. abort outside a sweep is a no-op.
REQ-027 abort and start asserted together SHALL give abort priority; start is ignored.
REQ-028 mismatch_cnt SHALL saturate at 32; overflow is impossible by construction and must not wrap.

Reset
REQ-029 When rst_n is low: state=IDLE, stim=0, vec_idx=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail_idx=0, first_fail_valid=0, asynchronously.
REQ-030 Reset asserted mid-sweep SHALL abandon the sweep; after release no sweep runs until a new start.

Verification
REQ-031 Golden model connected, default SETTLE -> done at cycle 192, mismatch_cnt=0, pass=1, first_fail_valid=0.
REQ-032 resp_out2 stuck at 0, resp_out1 correct -> mismatch_cnt=20, first_fail_idx=0, pass=0.
REQ-033 resp_out1 stuck at 1, resp_out2 correct -> mismatch_cnt=16, first_fail_idx=4.
REQ-034 abort during vector 10 SETTLE -> IDLE next cycle, stim=0, done=0; next start restarts at vec_idx=0 with counts cleared.
REQ-035 start pulsed at vector 5 -> ignored, sweep length unchanged; rst_n low during vector 20 -> all outputs at reset values immediately.
REQ-036 SETTLE_CYCLES=1 with the golden model -> done at cycle 96 and stim stable throughout each SETTLE/SAMPLE window.
